// File: rtl/pe_loader_pkg.sv
// pe_loader_pkg: state encoding and default sizing shared by the pe_con BRAM loader.
package pe_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } loader_state_t;

    // 64x64 matrix plus a 64-element vector
    localparam int unsigned DEFAULT_LOAD_WORDS = 4160;
    localparam int unsigned DEFAULT_ADDR_STEP  = 4;
    localparam logic [3:0]  BRAM_WE_FULL       = 4'hF;

endpackage

// File: rtl/bram_port_mux.sv
// bram_port_mux: hands the single BRAM port to either the loader or pe_con,
// and fans the read data straight back to pe_con.
module bram_port_mux
    import pe_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  pe_owns,
    input  logic [31:0]           ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wrdata,
    input  logic [3:0]            ld_we,
    input  logic [31:0]           pe_addr,
    input  logic [DATA_WIDTH-1:0] pe_wrdata,
    input  logic [3:0]            pe_we,
    output logic [31:0]           bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wrdata,
    output logic [3:0]            bram_we,
    input  logic [DATA_WIDTH-1:0] bram_rddata,
    output logic [DATA_WIDTH-1:0] pe_rddata
);

    assign bram_addr   = pe_owns ? pe_addr   : ld_addr;
    assign bram_wrdata = pe_owns ? pe_wrdata : ld_wrdata;
    assign bram_we     = pe_owns ? pe_we     : ld_we;
    assign pe_rddata   = bram_rddata;

endmodule

// File: rtl/pe_bram_loader.sv
// pe_bram_loader: streams one job of operand words into the shared BRAM,
// starts pe_con, lends it the BRAM port until it reports done.
// Optional build macro LOADER_CKSUM_EN enables the running checksum on cksum.
module pe_bram_loader
    import pe_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LOAD_WORDS = DEFAULT_LOAD_WORDS,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned ADDR_STEP  = DEFAULT_ADDR_STEP
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err_len,
    output logic [31:0]           cksum,
    output logic                  pe_start,
    input  logic                  pe_done,
    input  logic [31:0]           pe_bram_addr,
    input  logic [DATA_WIDTH-1:0] pe_bram_wrdata,
    input  logic [3:0]            pe_bram_we,
    output logic [DATA_WIDTH-1:0] pe_bram_rddata,
    output logic [31:0]           BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_WRDATA,
    output logic [3:0]            BRAM_WE,
    output logic                  BRAM_CLK,
    input  logic [DATA_WIDTH-1:0] BRAM_RDDATA
);

    localparam int unsigned      CNT_W        = $clog2(LOAD_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX     = CNT_W'(LOAD_WORDS - 1);
    localparam logic [31:0]      ADDR_STEP_32 = 32'(ADDR_STEP);

    loader_state_t         state;
    loader_state_t         state_next;
    logic [CNT_W-1:0]      word_cnt;
    logic [31:0]           ld_addr;
    logic [DATA_WIDTH-1:0] ld_wrdata;
    logic [3:0]            ld_we;
    logic                  accept;
    logic                  is_last_word;
    logic                  early_last;

    assign BRAM_CLK     = aclk;
    assign accept       = s_valid & s_ready;
    assign is_last_word = (word_cnt == LAST_IDX);
    assign early_last   = accept & s_last & ~is_last_word;

    // State register; reset abandons any job in flight
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus handshake and status strobes
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        pe_start   = 1'b0;
        done       = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE, ST_LOAD: begin
                s_ready = ~areset;
                if (accept) begin
                    if (is_last_word) begin
                        state_next = ST_START;
                    end else if (s_last) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_START: begin
                pe_start   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (pe_done) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Word counter, length error strobe and the registered loader write port
    always_ff @(posedge aclk) begin
        if (areset) begin
            word_cnt  <= '0;
            ld_addr   <= BASE_ADDR;
            ld_wrdata <= '0;
            ld_we     <= '0;
            err_len   <= 1'b0;
        end else begin
            ld_we   <= '0;
            err_len <= early_last;
            if (accept) begin
                ld_addr   <= BASE_ADDR + ADDR_STEP_32 * 32'(word_cnt);
                ld_wrdata <= s_data;
                ld_we     <= BRAM_WE_FULL;
                word_cnt  <= early_last ? '0 : word_cnt + CNT_W'(1);
            end else if (state == ST_FIN) begin
                word_cnt <= '0;
            end
        end
    end

`ifdef LOADER_CKSUM_EN
    logic [31:0] cksum_q;

    // Running sum of accepted words; the first beat of a job restarts it
    always_ff @(posedge aclk) begin
        if (areset) begin
            cksum_q <= '0;
        end else if (accept) begin
            cksum_q <= (state == ST_IDLE) ? 32'(s_data) : cksum_q + 32'(s_data);
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = 32'h0000_0000;
`endif

    bram_port_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .pe_owns     (state == ST_WAIT),
        .ld_addr     (ld_addr),
        .ld_wrdata   (ld_wrdata),
        .ld_we       (ld_we),
        .pe_addr     (pe_bram_addr),
        .pe_wrdata   (pe_bram_wrdata),
        .pe_we       (pe_bram_we),
        .bram_addr   (BRAM_ADDR),
        .bram_wrdata (BRAM_WRDATA),
        .bram_we     (BRAM_WE),
        .bram_rddata (BRAM_RDDATA),
        .pe_rddata   (pe_bram_rddata)
    );

endmodule

// File: tb/tb_pe_bram_loader.sv
// tb_pe_bram_loader: directed jobs into pe_bram_loader; every BRAM write is
// matched against a queue of expected writes by an independent monitor.
module tb_pe_bram_loader;

    localparam int WORDS = 4160;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
    } wr_t;

    logic        aclk           = 1'b0;
    logic        areset         = 1'b1;
    logic        s_valid        = 1'b0;
    logic        s_last         = 1'b0;
    logic        pe_done        = 1'b0;
    logic [31:0] s_data         = 32'h0;
    logic [31:0] pe_bram_addr   = 32'h0;
    logic [31:0] pe_bram_wrdata = 32'h0;
    logic [3:0]  pe_bram_we     = 4'h0;
    logic [31:0] BRAM_RDDATA    = 32'h0;

    logic        s_ready;
    logic        busy;
    logic        done;
    logic        err_len;
    logic        pe_start;
    logic        BRAM_CLK;
    logic [31:0] cksum;
    logic [31:0] pe_bram_rddata;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;

    int  n_checks     = 0;
    int  n_fail       = 0;
    int  cycle_cnt    = 0;
    int  start_cnt    = 0;
    int  done_cnt     = 0;
    int  err_cnt      = 0;
    int  start_cyc    = -100;
    int  err_cyc      = -100;
    int  last_acc_cyc = 0;
    wr_t exp_q[$];
    wr_t mon_e;

    logic [31:0] mem [0:WORDS-1];
    logic        mem_clear = 1'b0;

    logic [31:0] exp_sum_seq;
    logic [31:0] exp_sum_ones;

    pe_bram_loader dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_last         (s_last),
        .s_ready        (s_ready),
        .busy           (busy),
        .done           (done),
        .err_len        (err_len),
        .cksum          (cksum),
        .pe_start       (pe_start),
        .pe_done        (pe_done),
        .pe_bram_addr   (pe_bram_addr),
        .pe_bram_wrdata (pe_bram_wrdata),
        .pe_bram_we     (pe_bram_we),
        .pe_bram_rddata (pe_bram_rddata),
        .BRAM_ADDR      (BRAM_ADDR),
        .BRAM_WRDATA    (BRAM_WRDATA),
        .BRAM_WE        (BRAM_WE),
        .BRAM_CLK       (BRAM_CLK),
        .BRAM_RDDATA    (BRAM_RDDATA)
    );

    // Free-running clock
    initial begin
        forever #5 aclk = ~aclk;
    end

    // Cycle counter used for latency measurements
    always @(posedge aclk) begin
        cycle_cnt++;
    end

    // Behavioural BRAM contents, for whole-image comparisons
    always @(posedge aclk) begin
        if (mem_clear) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= 32'hFFFF_FFFF;
        end else if (BRAM_WE == 4'hF && BRAM_ADDR < 32'(WORDS * 4)) begin
            mem[BRAM_ADDR[14:2]] <= BRAM_WRDATA;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: count strobes and pop one expected write per BRAM write seen
    always @(negedge aclk) begin
        if (pe_start === 1'b1) begin
            start_cnt++;
            start_cyc = cycle_cnt;
        end
        if (done === 1'b1) done_cnt++;
        if (err_len === 1'b1) begin
            err_cnt++;
            err_cyc = cycle_cnt;
        end
        if (BRAM_WE !== 4'h0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got addr 0x%08h we 0x%h expected no write",
                         BRAM_ADDR, BRAM_WE);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("wr_addr", BRAM_ADDR, mon_e.addr);
                check_output("wr_data", BRAM_WRDATA, mon_e.data);
                check_output("wr_we", {28'h0, BRAM_WE}, {28'h0, mon_e.we});
            end
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic drive_edge();
        @(posedge aclk);
        #1;
    endtask

    // Offer one beat; on acceptance the expected write at word idx is queued
    task automatic send_word(input logic [31:0] data, input logic last, input int idx);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = data;
        s_last  = last;
        step();
        while (s_ready !== 1'b1 && waited < 200) begin
            waited++;
            step();
        end
        if (s_ready === 1'b1) begin
            exp_q.push_back('{addr: 32'(idx * 4), data: data, we: 4'hF});
            last_acc_cyc = cycle_cnt;
        end else begin
            check_output("accept_timeout", {31'h0, s_ready}, 32'h1);
        end
        drive_edge();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Stream n words; s_last on last_at; optional idle cycle between beats
    task automatic apply_stimulus(input int n, input int last_at, input bit gap, input bit ones);
        drive_edge();
        for (int k = 0; k < n; k++) begin
            if (k == n - 1) pe_bram_we = 4'h0;
            send_word(ones ? 32'h1 : 32'(k), (k == last_at), k);
            if (gap && k != n - 1) begin
                step();
                check_output("ready_in_gap", {31'h0, s_ready}, 32'h1);
                drive_edge();
            end
        end
    endtask

    // Follow pe_start, optionally exercise pe_con's port, then return done
    task automatic finish_job(input bit pe_access);
        int sb = start_cnt;
        int db = done_cnt;
        int n  = 0;
        step();
        while (start_cnt == sb && n < 20) begin
            n++;
            step();
        end
        check_output("pe_start_seen", 32'(start_cnt - sb), 32'h1);
        check_output("pe_start_latency", 32'(start_cyc - last_acc_cyc), 32'h1);
        step();
        check_output("wait_busy", {31'h0, busy}, 32'h1);
        check_output("wait_ready", {31'h0, s_ready}, 32'h0);
        if (pe_access) begin
            drive_edge();
            pe_bram_addr   = 32'h0000_0100;
            pe_bram_wrdata = 32'h5A5A_0000;
            pe_bram_we     = 4'hF;
            BRAM_RDDATA    = 32'hCAFE_0042;
            s_valid        = 1'b1;
            s_data         = 32'h0000_0077;
            exp_q.push_back('{addr: 32'h100, data: 32'h5A5A_0000, we: 4'hF});
            step();
            check_output("pe_addr_mux", BRAM_ADDR, 32'h0000_0100);
            check_output("pe_we_mux", {28'h0, BRAM_WE}, 32'hF);
            check_output("pe_rddata", pe_bram_rddata, 32'hCAFE_0042);
            check_output("wait_ready_valid", {31'h0, s_ready}, 32'h0);
            drive_edge();
            pe_bram_we = 4'h0;
            s_valid    = 1'b0;
        end
        repeat (50) @(posedge aclk);
        #1;
        pe_done = 1'b1;
        n = 0;
        step();
        while (done_cnt == db && n < 20) begin
            n++;
            step();
        end
        drive_edge();
        pe_done = 1'b0;
        repeat (3) step();
        check_output("done_pulses", 32'(done_cnt - db), 32'h1);
        check_output("start_pulses", 32'(start_cnt - sb), 32'h1);
        check_output("idle_after_fin", {31'h0, busy}, 32'h0);
        check_output("queue_drained", 32'(exp_q.size()), 32'h0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        int eb;
        int sb;
`ifdef LOADER_CKSUM_EN
        exp_sum_seq  = 32'd8650720;
        exp_sum_ones = 32'd4160;
`else
        exp_sum_seq  = 32'd0;
        exp_sum_ones = 32'd0;
`endif
        $display("[TB] reset");
        repeat (3) @(posedge aclk);
        step();
        check_output("rst_busy", {31'h0, busy}, 32'h0);
        check_output("rst_ready", {31'h0, s_ready}, 32'h0);
        check_output("rst_we", {28'h0, BRAM_WE}, 32'h0);
        check_output("rst_addr", BRAM_ADDR, 32'h0);
        check_output("rst_wrdata", BRAM_WRDATA, 32'h0);
        check_output("rst_done", {31'h0, done}, 32'h0);
        check_output("rst_err", {31'h0, err_len}, 32'h0);
        check_output("rst_start", {31'h0, pe_start}, 32'h0);
        check_output("rst_cksum", cksum, 32'h0);
        check_output("bram_clk_low", {31'h0, BRAM_CLK}, 32'h0);
        drive_edge();
        areset = 1'b0;
        step();
        check_output("idle_ready", {31'h0, s_ready}, 32'h1);

        $display("[TB] job 1: full job, pe_con traffic ignored while loading");
        drive_edge();
        pe_bram_addr   = 32'hDEAD_0000;
        pe_bram_wrdata = 32'h0000_0BAD;
        pe_bram_we     = 4'hF;
        apply_stimulus(WORDS, WORDS - 1, 1'b0, 1'b0);
        finish_job(1'b1);
        check_output("cksum_job1", cksum, exp_sum_seq);

        $display("[TB] job 2: valid toggling every cycle");
        drive_edge();
        mem_clear = 1'b1;
        drive_edge();
        mem_clear = 1'b0;
        apply_stimulus(WORDS, WORDS - 1, 1'b1, 1'b0);
        finish_job(1'b0);
        bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== 32'(i)) bad++;
        check_output("contents_job2", 32'(bad), 32'h0);

        $display("[TB] job 3: early s_last on word 9");
        eb = err_cnt;
        sb = start_cnt;
        apply_stimulus(10, 9, 1'b0, 1'b0);
        step();
        check_output("err_pulse", {31'h0, err_len}, 32'h1);
        check_output("err_latency", 32'(err_cyc - last_acc_cyc), 32'h1);
        check_output("err_busy", {31'h0, busy}, 32'h0);
        step();
        check_output("err_clear", {31'h0, err_len}, 32'h0);
        repeat (10) step();
        check_output("err_count", 32'(err_cnt - eb), 32'h1);
        check_output("err_no_start", 32'(start_cnt - sb), 32'h0);
        check_output("err_queue", 32'(exp_q.size()), 32'h0);

        $display("[TB] job 4: reset at word 2000, then a fresh job");
        sb = start_cnt;
        drive_edge();
        for (int k = 0; k < 2000; k++) send_word(32'(k), 1'b0, k);
        areset  = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'd2000;
        step();
        drive_edge();
        step();
        check_output("abort_we", {28'h0, BRAM_WE}, 32'h0);
        check_output("abort_busy", {31'h0, busy}, 32'h0);
        drive_edge();
        areset  = 1'b0;
        s_valid = 1'b0;
        repeat (5) step();
        check_output("abort_queue", 32'(exp_q.size()), 32'h0);
        check_output("abort_no_start", 32'(start_cnt - sb), 32'h0);
        apply_stimulus(WORDS, WORDS - 1, 1'b0, 1'b0);
        finish_job(1'b0);
        check_output("cksum_job4", cksum, exp_sum_seq);

        $display("[TB] job 5: all-ones checksum, no s_last");
        apply_stimulus(WORDS, -1, 1'b0, 1'b1);
        finish_job(1'b0);
        check_output("cksum_ones", cksum, exp_sum_ones);
        repeat (3) step();
        check_output("cksum_hold", cksum, exp_sum_ones);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
